// File: rtl/router_pkt_tx.sv
// Synthesizable packet source for the 1x3 router input side: buffers a host payload, then emits
// header, payload and parity bytes under router busy flow control.
module router_pkt_tx #(
   parameter int unsigned MAX_LEN = 63,
   parameter int unsigned GAP     = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic [5:0] pay_len,
   input  logic       corrupt_parity,
   output logic       ready,
   input  logic [7:0] pay_data,
   input  logic       pay_valid,
   output logic       pay_ready,
   output logic [7:0] tx_data,
   output logic       pkt_valid,
   input  logic       busy,
   output logic       done,
   output logic       cmd_err
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StHeader,
      StPayload,
      StParity,
      StGap
   } state_e;

   localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_e     state_q;
   logic [1:0] dest_q;
   logic [5:0] len_q;
   logic       corrupt_q;
   logic [5:0] wr_ptr_q;
   logic [5:0] rd_ptr_q;
   logic [7:0] parity_q;
   logic [3:0] gap_cnt_q;
   logic [7:0] pkt_buf [64];

   logic       cmd_legal;
   logic       wr_en;

   assign cmd_legal = (dest_addr != 2'd3) && (pay_len != 6'd0) && (pay_len <= 6'(MAX_LEN));
   assign wr_en     = (state_q == StLoad) && pay_valid;

   // Payload storage has no reset; contents are only read after a full load.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         pkt_buf[wr_ptr_q] <= pay_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         dest_q    <= 2'd0;
         len_q     <= 6'd0;
         corrupt_q <= 1'b0;
         wr_ptr_q  <= 6'd0;
         rd_ptr_q  <= 6'd0;
         parity_q  <= 8'd0;
         gap_cnt_q <= 4'd0;
         ready     <= 1'b0;
         pay_ready <= 1'b0;
         tx_data   <= 8'd0;
         pkt_valid <= 1'b0;
         done      <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ready <= 1'b1;
               if (ready && start) begin
                  if (cmd_legal) begin
                     dest_q    <= dest_addr;
                     len_q     <= pay_len;
                     corrupt_q <= corrupt_parity;
                     wr_ptr_q  <= 6'd0;
                     rd_ptr_q  <= 6'd0;
                     ready     <= 1'b0;
                     pay_ready <= 1'b1;
                     state_q   <= StLoad;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (pay_valid) begin
                  wr_ptr_q <= wr_ptr_q + 6'd1;
                  if (wr_ptr_q == len_q - 6'd1) begin
                     pay_ready <= 1'b0;
                     tx_data   <= {len_q, dest_q};
                     parity_q  <= {len_q, dest_q};
                     pkt_valid <= 1'b1;
                     state_q   <= StHeader;
                  end
               end
            end
            StHeader: begin
               if (!busy) begin
                  tx_data  <= pkt_buf[6'd0];
                  rd_ptr_q <= 6'd0;
                  state_q  <= StPayload;
               end
            end
            StPayload: begin
               // tx_data holds the byte being accepted, so it folds straight into parity.
               if (!busy) begin
                  parity_q <= parity_q ^ tx_data;
                  if (rd_ptr_q == len_q - 6'd1) begin
                     pkt_valid <= 1'b0;
                     tx_data   <= parity_q ^ tx_data ^ {8{corrupt_q}};
                     state_q   <= StParity;
                  end else begin
                     rd_ptr_q <= rd_ptr_q + 6'd1;
                     tx_data  <= pkt_buf[rd_ptr_q + 6'd1];
                  end
               end
            end
            StParity: begin
               if (!busy) begin
                  done      <= 1'b1;
                  tx_data   <= 8'd0;
                  gap_cnt_q <= 4'd0;
                  state_q   <= (GAP == 0) ? StIdle : StGap;
               end
            end
            StGap: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= StIdle;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
